fetch_pc_ctrl: RTL and testbench

Program-counter and fetch-request controller for the instruction-fetch stage.
- Consumes the single-bit redirect decision (branch-taken OR jump) produced by the upstream orGate combine logic.
- Holds the PC and issues fetch requests to instruction memory with a valid/ready handshake.
- Handles pipeline stalls and emits squash bubbles to downstream stages after a redirect.

---
 rtl/fetch_pc_ctrl.sv | 100 ++++++++++
 tb/tb_fetch_pc_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_ctrl.sv
// fetch_pc_ctrl: PC register and fetch-request FSM with redirect flush and stall handling
module fetch_pc_ctrl #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int PC_INC = 4,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_target,
  input  logic             fetch_ready,
  output logic [WIDTH-1:0] pc,
  output logic             fetch_valid,
  output logic             bubble,
  output logic             misaligned,
  output logic [1:0]       state
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STALL = 2'd2, FLUSH = 2'd3} state_t;
  localparam logic [WIDTH-1:0] LOW_MASK = WIDTH'(PC_INC - 1);
  localparam logic [WIDTH-1:0] INC = WIDTH'(PC_INC);
  localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);
  state_t state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic fetch_valid_q, fetch_valid_d;
  logic bubble_q, bubble_d;
  logic misaligned_q, misaligned_d;
  logic [3:0] cnt_q, cnt_d;
  // next state: redirect overrides everything but reset, stall only matters in RUN/STALL/end of FLUSH
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    fetch_valid_d = fetch_valid_q;
    bubble_d = bubble_q;
    misaligned_d = 1'b0;
    cnt_d = cnt_q;
    if (redirect) begin
      state_d = FLUSH;
      pc_d = redirect_target & ~LOW_MASK;
      fetch_valid_d = 1'b0;
      bubble_d = 1'b1;
      misaligned_d = |(redirect_target & LOW_MASK);
      cnt_d = FLUSH_LAST;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = RUN;
          fetch_valid_d = 1'b1;
        end
        RUN: begin
          if (stall) begin
            state_d = STALL;
            fetch_valid_d = 1'b0;
          end else if (fetch_valid_q && fetch_ready) begin
            pc_d = pc_q + INC;
          end
        end
        STALL: begin
          if (!stall) begin
            state_d = RUN;
            fetch_valid_d = 1'b1;
          end
        end
        default: begin
          if (cnt_q == 4'd0) begin
            state_d = stall ? STALL : RUN;
            bubble_d = 1'b0;
            fetch_valid_d = !stall;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      endcase
    end
  end
  // state and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q <= RESET_PC;
      fetch_valid_q <= 1'b0;
      bubble_q <= 1'b0;
      misaligned_q <= 1'b0;
      cnt_q <= 4'd0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      fetch_valid_q <= fetch_valid_d;
      bubble_q <= bubble_d;
      misaligned_q <= misaligned_d;
      cnt_q <= cnt_d;
    end
  end
  assign pc = pc_q;
  assign fetch_valid = fetch_valid_q;
  assign bubble = bubble_q;
  assign misaligned = misaligned_q;
  assign state = state_q;
endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// tb_fetch_pc_ctrl: directed and randomized checks of fetch_pc_ctrl against a behavioural model
module tb_fetch_pc_ctrl;
  localparam int FC = 2;
  localparam int INC = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic stall = 1'b0;
  logic redirect = 1'b0;
  logic [31:0] redirect_target = '0;
  logic fetch_ready = 1'b0;
  logic [31:0] pc;
  logic fetch_valid, bubble, misaligned;
  logic [1:0] state;
  int n_tests = 0;
  int n_fail = 0;
  logic [31:0] m_pc = '0;
  logic m_fv = 1'b0, m_bub = 1'b0, m_mis = 1'b0;
  logic [1:0] m_st = 2'd0;
  int m_left = 0;

  fetch_pc_ctrl #(.WIDTH(32), .RESET_PC(32'h0), .PC_INC(INC), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_target(redirect_target), .fetch_ready(fetch_ready),
    .pc(pc), .fetch_valid(fetch_valid), .bubble(bubble), .misaligned(misaligned), .state(state)
  );

  always #5 clk = ~clk;

  function automatic logic [36:0] obs();
    return {pc, fetch_valid, bubble, misaligned, state};
  endfunction

  function automatic logic [36:0] exp_v();
    return {m_pc, m_fv, m_bub, m_mis, m_st};
  endfunction

  // m_left counts bubble cycles still to be shown, including the current one
  task automatic cycle();
    @(posedge clk);
    if (reset) begin
      m_pc = 32'h0; m_fv = 0; m_bub = 0; m_mis = 0; m_st = 2'd0; m_left = 0;
    end else begin
      m_mis = 0;
      if (redirect) begin
        m_pc = redirect_target - (redirect_target % INC);
        m_mis = (redirect_target % INC) != 0;
        m_st = 2'd3; m_bub = 1; m_fv = 0; m_left = FC;
      end else if (m_st == 2'd0) begin
        m_st = 2'd1; m_fv = 1;
      end else if (m_st == 2'd1) begin
        if (stall) begin m_st = 2'd2; m_fv = 0; end
        else if (fetch_ready) m_pc = m_pc + INC;
      end else if (m_st == 2'd2) begin
        if (!stall) begin m_st = 2'd1; m_fv = 1; end
      end else begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_bub = 0; m_st = stall ? 2'd2 : 2'd1; m_fv = !stall;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1; stall = 0; redirect = 0; fetch_ready = 0;
    cycle(); cycle();
    n_tests++;
    if (obs() !== 37'h0) begin n_fail++; $display("FAIL reset_state: got %h want %h", obs(), 37'h0); end
    reset = 0;
    cycle();
    n_tests++;
    if ({state, fetch_valid, pc} !== {2'd1, 1'b1, 32'h0}) begin
      n_fail++; $display("FAIL start_run: got st=%0d fv=%b pc=%h want st=1 fv=1 pc=0", state, fetch_valid, pc);
    end
  endtask

  task automatic test_streaming();
    fetch_ready = 1;
    for (int i = 1; i <= 4; i++) begin
      cycle();
      n_tests++;
      if (pc !== 32'(4 * i) || obs() !== exp_v()) begin
        n_fail++; $display("FAIL stream_%0d: got %h want pc=%h model %h", i, obs(), 4 * i, exp_v());
      end
    end
    fetch_ready = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_tests++;
      if (pc !== 32'h10 || fetch_valid !== 1'b1) begin
        n_fail++; $display("FAIL hold_not_ready: got pc=%h fv=%b want pc=10 fv=1", pc, fetch_valid);
      end
    end
  endtask

  task automatic test_stall();
    redirect = 1; redirect_target = 32'h8;
    cycle();
    redirect = 0;
    cycle(); cycle();
    fetch_ready = 1; stall = 1;
    for (int i = 0; i < 2; i++) begin
      cycle();
      n_tests++;
      if ({state, fetch_valid, pc} !== {2'd2, 1'b0, 32'h8}) begin
        n_fail++; $display("FAIL stall_hold: got st=%0d fv=%b pc=%h want st=2 fv=0 pc=8", state, fetch_valid, pc);
      end
    end
    stall = 0; fetch_ready = 0;
    cycle();
    n_tests++;
    if ({state, fetch_valid, pc} !== {2'd1, 1'b1, 32'h8}) begin
      n_fail++; $display("FAIL stall_release: got st=%0d fv=%b pc=%h want st=1 fv=1 pc=8", state, fetch_valid, pc);
    end
    fetch_ready = 1;
    cycle();
    fetch_ready = 0;
    n_tests++;
    if (pc !== 32'hC) begin n_fail++; $display("FAIL stall_next_fire: got pc=%h want c", pc); end
  endtask

  task automatic test_redirect();
    redirect = 1; stall = 1; redirect_target = 32'h100;
    cycle();
    redirect = 0; stall = 0;
    n_tests++;
    if ({bubble, fetch_valid, state} !== {1'b1, 1'b0, 2'd3}) begin
      n_fail++; $display("FAIL redirect_bubble1: got bub=%b fv=%b st=%0d want 1 0 3", bubble, fetch_valid, state);
    end
    cycle();
    n_tests++;
    if ({bubble, fetch_valid} !== 2'b10) begin
      n_fail++; $display("FAIL redirect_bubble2: got bub=%b fv=%b want 1 0", bubble, fetch_valid);
    end
    cycle();
    n_tests++;
    if ({bubble, fetch_valid, state, pc} !== {1'b0, 1'b1, 2'd1, 32'h100}) begin
      n_fail++; $display("FAIL redirect_done: got bub=%b fv=%b st=%0d pc=%h want 0 1 1 100", bubble, fetch_valid, state, pc);
    end
  endtask

  task automatic test_misaligned();
    redirect = 1; redirect_target = 32'h102;
    cycle();
    redirect = 0;
    n_tests++;
    if ({pc, misaligned} !== {32'h100, 1'b1}) begin
      n_fail++; $display("FAIL misaligned_pulse: got pc=%h mis=%b want 100 1", pc, misaligned);
    end
    cycle();
    n_tests++;
    if (misaligned !== 1'b0) begin n_fail++; $display("FAIL misaligned_clear: got %b want 0", misaligned); end
    cycle();
  endtask

  task automatic test_wrap();
    redirect = 1; redirect_target = 32'hFFFF_FFFC;
    cycle();
    redirect = 0;
    cycle(); cycle();
    fetch_ready = 1;
    cycle();
    fetch_ready = 0;
    n_tests++;
    if ({pc, state, fetch_valid} !== {32'h0, 2'd1, 1'b1}) begin
      n_fail++; $display("FAIL wrap: got pc=%h st=%0d fv=%b want 0 1 1", pc, state, fetch_valid);
    end
  endtask

  task automatic test_reset_mid_flush();
    redirect = 1; redirect_target = 32'h44;
    cycle();
    redirect = 0; reset = 1;
    cycle();
    n_tests++;
    if (obs() !== 37'h0) begin n_fail++; $display("FAIL reset_mid_flush: got %h want %h", obs(), 37'h0); end
    reset = 0;
    cycle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 99) < 2);
      stall = ($urandom_range(0, 99) < 25);
      redirect = ($urandom_range(0, 99) < 10);
      fetch_ready = ($urandom_range(0, 99) < 70);
      redirect_target = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom;
      cycle();
      n_tests++;
      if (obs() !== exp_v()) begin
        n_fail++; $display("FAIL random_%0d: got %h want %h", i, obs(), exp_v());
      end
    end
    reset = 0; stall = 0; redirect = 0; fetch_ready = 0;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_stall();
    test_redirect();
    test_misaligned();
    test_wrap();
    test_reset_mid_flush();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
